// File: rtl/cube_pkg.sv
// cube_pkg: types shared by the move input stage and the cube logic unit.
//   face_t        3-bit face code U, D, L, R, F, B (0-5); 6 and 7 are unused codes
//   move_t        one queued move: {face, ccw}
//   NUM_FACES     number of legal face codes
//   MOVE_W        packed width of move_t
//   face_is_valid true when a raw 3-bit face code names a real face
package cube_pkg;

   typedef enum logic [2:0] {
      FACE_U = 3'd0,
      FACE_D = 3'd1,
      FACE_L = 3'd2,
      FACE_R = 3'd3,
      FACE_F = 3'd4,
      FACE_B = 3'd5
   } face_t;

   typedef struct packed {
      face_t face;
      logic  ccw;
   } move_t;

   localparam int NUM_FACES = 6;
   localparam int MOVE_W    = $bits(move_t);

   function automatic logic face_is_valid(input logic [2:0] face);
      return (int'(face) < NUM_FACES);
   endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: small synchronous FIFO holding queued moves.
//   clk, srst   clock and synchronous active-high reset
//   push        write push_data this cycle (ignored when full unless popping)
//   push_data   payload to write
//   pop         remove the head entry this cycle (ignored when empty)
//   head_data   registered head entry; keeps the last head when empty, 0 after reset
//   full/empty  occupancy flags
//   count       number of entries held (0..DEPTH)
module move_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [AW:0]      count_reg, count_next;
   logic [WIDTH-1:0] head_reg, head_next;
   logic             do_push, do_pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));

   // A full FIFO still accepts a push when the head leaves in the same cycle,
   // since the slot being written is the one being vacated.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_next = do_push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
      rd_ptr_next = do_pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
      count_next  = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
      // Registered read of the next head. When that slot is being written this
      // very cycle (empty FIFO receiving its first entry) take the write data.
      // With nothing left, hold the previous head so the outputs stay put.
      head_next = head_reg;
      if (count_next != '0) begin
         if (do_push && (wr_ptr_reg == rd_ptr_next))
            head_next = push_data;
         else
            head_next = mem[rd_ptr_next];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
      end
   end

   assign head_data = head_reg;
   assign count     = count_reg;

endmodule

// File: rtl/move_queue.sv
// move_queue: turns a raw pushbutton plus face/direction switches into queued
// move commands for the cube logic unit.
//   CLOCK_50     system clock
//   reset        synchronous active-high reset
//   KEY_move     raw active-low pushbutton (asynchronous)
//   SW_face      raw face select, 0-5 legal (asynchronous)
//   SW_ccw       raw direction select, 1 = counter-clockwise (asynchronous)
//   move_ready   logic unit accepts the head move this cycle
//   move_valid   head of the queue holds a move
//   move_face    face of the head move
//   move_ccw     direction of the head move
//   queue_count  entries held
//   overflow     sticky: a legal press was dropped because the queue was full
//   bad_face     one-cycle pulse after a press that selected face 6 or 7
module move_queue #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DEPTH           = 4
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     KEY_move,
   input  logic [2:0]               SW_face,
   input  logic                     SW_ccw,
   input  logic                     move_ready,
   output logic                     move_valid,
   output logic [2:0]               move_face,
   output logic                     move_ccw,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic                     overflow,
   output logic                     bad_face
);

   import cube_pkg::*;

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W:0]  CNT_LAST = (CNT_W+1)'(DEBOUNCE_CYCLES - 1);

   logic             key_meta_reg, key_sync_reg;
   logic [3:0]       sw_raw, sw_sync;
   logic             deb_reg, deb_prev_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W:0]   cnt_inc;
   logic             press, face_ok, push, pop;
   logic             bad_face_reg, overflow_reg;
   logic             fifo_full, fifo_empty;
   move_t            push_move, head_move;

   // Two-flop synchronisers for the switch bits; they idle at 0.
   assign sw_raw = {SW_ccw, SW_face};

   for (genvar gi = 0; gi < 4; gi++) begin : g_sw_sync
      logic meta_reg, sync_reg;
      always_ff @(posedge CLOCK_50) begin
         if (reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
         end else begin
            meta_reg <= sw_raw[gi];
            sync_reg <= meta_reg;
         end
      end
      assign sw_sync[gi] = sync_reg;
   end

   // Key synchroniser and debounce. The key flops idle at 1 (released), so a
   // key already held through reset is seen as a fresh press afterwards.
   // The count advances while the synced key differs from the debounced level
   // and restarts on any bounce back.
   assign cnt_inc = {1'b0, cnt_reg} + (CNT_W+1)'(1);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         key_meta_reg <= 1'b1;
         key_sync_reg <= 1'b1;
         deb_reg      <= 1'b1;
         deb_prev_reg <= 1'b1;
         cnt_reg      <= '0;
      end else begin
         key_meta_reg <= KEY_move;
         key_sync_reg <= key_meta_reg;
         deb_prev_reg <= deb_reg;
         if (key_sync_reg == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_inc == CNT_LAST) begin
            deb_reg <= key_sync_reg;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_inc[CNT_W-1:0];
         end
      end
   end

   // Falling edge of the debounced level is a press; releases are ignored.
   assign press   = deb_prev_reg && !deb_reg;
   assign face_ok = face_is_valid(sw_sync[2:0]);
   assign push    = press && face_ok;
   assign pop     = move_valid && move_ready;

   always_comb begin
      push_move.face = face_t'(sw_sync[2:0]);
      push_move.ccw  = sw_sync[3];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         bad_face_reg <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         bad_face_reg <= press && !face_ok;
         if (push && fifo_full && !pop)
            overflow_reg <= 1'b1;
      end
   end

   move_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (MOVE_W)
   ) u_fifo (
      .clk       (CLOCK_50),
      .srst      (reset),
      .push      (push),
      .push_data (push_move),
      .pop       (pop),
      .head_data (head_move),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (queue_count)
   );

   // Valid comes purely from registered occupancy, never from move_ready.
   assign move_valid = !fifo_empty;
   assign move_face  = head_move.face;
   assign move_ccw   = head_move.ccw;
   assign overflow   = overflow_reg;
   assign bad_face   = bad_face_reg;

endmodule

// File: tb/tb_move_queue.sv
// tb_move_queue: directed self-checking bench for move_queue with
// DEBOUNCE_CYCLES=4 and DEPTH=4. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point.
module tb_move_queue;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       KEY_move;
   logic [2:0] SW_face;
   logic       SW_ccw;
   logic       move_ready;
   logic       move_valid;
   logic [2:0] move_face;
   logic       move_ccw;
   logic [2:0] queue_count;
   logic       overflow;
   logic       bad_face;

   int checks = 0;
   int errors = 0;

   move_queue #(
      .DEBOUNCE_CYCLES (4),
      .DEPTH           (4)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .KEY_move    (KEY_move),
      .SW_face     (SW_face),
      .SW_ccw      (SW_ccw),
      .move_ready  (move_ready),
      .move_valid  (move_valid),
      .move_face   (move_face),
      .move_ccw    (move_ccw),
      .queue_count (queue_count),
      .overflow    (overflow),
      .bad_face    (bad_face)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("[%0t] check %s observed=%0d expected=%0d", $time, tag, obs, exp);
   endtask

   // Full press/release cycle: switches settle, key held long enough to be
   // written into the queue, then released long enough to debounce the release.
   task automatic press_move(input logic [2:0] face, input logic ccw);
      SW_face = face;
      SW_ccw  = ccw;
      repeat (3) step();
      KEY_move = 1'b0;
      repeat (6) step();
      KEY_move = 1'b1;
      repeat (6) step();
   endtask

   initial begin
      int  waited;
      logic found;

      reset      = 1'b1;
      KEY_move   = 1'b1;
      SW_face    = 3'd0;
      SW_ccw     = 1'b0;
      move_ready = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_valid",    32'(move_valid),  0);
      check("rst_face",     32'(move_face),   0);
      check("rst_ccw",      32'(move_ccw),    0);
      check("rst_count",    32'(queue_count), 0);
      check("rst_overflow", 32'(overflow),    0);
      check("rst_bad_face", 32'(bad_face),    0);
      reset = 1'b0;
      repeat (2) step();

      // Single press: valid exactly 6 cycles after the key falls, popped at once
      move_ready = 1'b1;
      SW_face = 3'd3;
      SW_ccw  = 1'b1;
      repeat (3) step();
      KEY_move = 1'b0;
      repeat (5) step();
      check("t1_valid_early", 32'(move_valid), 0);
      step();
      check("t1_valid",  32'(move_valid),  1);
      check("t1_face",   32'(move_face),   3);
      check("t1_ccw",    32'(move_ccw),    1);
      check("t1_count",  32'(queue_count), 1);
      step();
      check("t1_popped_count", 32'(queue_count), 0);
      check("t1_popped_valid", 32'(move_valid),  0);
      check("t1_face_held",    32'(move_face),   3);
      KEY_move = 1'b1;
      repeat (8) step();
      check("t1_release_no_move", 32'(queue_count), 0);

      // Bounce: low 2, high 1, low held -> count restarts, one move
      move_ready = 1'b0;
      SW_face = 3'd2;
      SW_ccw  = 1'b0;
      repeat (3) step();
      KEY_move = 1'b0;
      repeat (2) step();
      KEY_move = 1'b1;
      step();
      KEY_move = 1'b0;
      repeat (4) step();
      check("t2_bounce_restart", 32'(queue_count), 0);
      repeat (2) step();
      check("t2_one_move", 32'(queue_count), 1);
      repeat (6) step();
      check("t2_still_one", 32'(queue_count), 1);
      KEY_move = 1'b1;
      repeat (8) step();
      SW_face = 3'd5;
      SW_ccw  = 1'b1;
      repeat (3) step();
      KEY_move = 1'b0;
      repeat (10) step();
      check("t2_second_move", 32'(queue_count), 2);
      KEY_move = 1'b1;
      move_ready = 1'b1;
      check("t2_head0_face", 32'(move_face), 2);
      check("t2_head0_ccw",  32'(move_ccw),  0);
      step();
      check("t2_head1_face", 32'(move_face), 5);
      check("t2_head1_ccw",  32'(move_ccw),  1);
      step();
      check("t2_drained", 32'(queue_count), 0);
      move_ready = 1'b0;
      repeat (6) step();

      // Five presses into a 4-deep queue with move_ready low
      press_move(3'd0, 1'b0);
      press_move(3'd1, 1'b1);
      press_move(3'd2, 1'b0);
      press_move(3'd4, 1'b1);
      check("t3_overflow_before", 32'(overflow), 0);
      press_move(3'd5, 1'b0);
      check("t3_count_full", 32'(queue_count), 4);
      check("t3_overflow",   32'(overflow),    1);
      move_ready = 1'b1;
      check("t3_d0_face", 32'(move_face), 0);
      check("t3_d0_ccw",  32'(move_ccw),  0);
      step();
      check("t3_d1_face", 32'(move_face), 1);
      check("t3_d1_ccw",  32'(move_ccw),  1);
      step();
      check("t3_d2_face", 32'(move_face), 2);
      step();
      check("t3_d3_face", 32'(move_face), 4);
      check("t3_d3_ccw",  32'(move_ccw),  1);
      step();
      check("t3_empty_valid", 32'(move_valid),  0);
      check("t3_empty_count", 32'(queue_count), 0);
      check("t3_overflow_sticky", 32'(overflow), 1);
      move_ready = 1'b0;

      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      check("rst2_overflow", 32'(overflow), 0);
      step();

      // Invalid face 7: bad_face pulses one cycle, nothing queued
      SW_face = 3'd7;
      SW_ccw  = 1'b0;
      repeat (3) step();
      KEY_move = 1'b0;
      repeat (5) step();
      check("t4_bad_face_pre", 32'(bad_face), 0);
      step();
      check("t4_bad_face",     32'(bad_face), 1);
      step();
      check("t4_bad_face_end", 32'(bad_face),    0);
      check("t4_count",        32'(queue_count), 0);
      check("t4_overflow",     32'(overflow),    0);
      KEY_move = 1'b1;
      repeat (6) step();

      // Full queue, press lands on the same edge as a pop
      press_move(3'd1, 1'b0);
      press_move(3'd2, 1'b1);
      press_move(3'd3, 1'b0);
      press_move(3'd4, 1'b1);
      check("t5_full", 32'(queue_count), 4);
      SW_face = 3'd5;
      SW_ccw  = 1'b1;
      repeat (3) step();
      KEY_move = 1'b0;
      repeat (5) step();
      move_ready = 1'b1;
      check("t5_head_before", 32'(move_face), 1);
      step();
      KEY_move = 1'b1;
      check("t5_count_kept", 32'(queue_count), 4);
      check("t5_no_overflow", 32'(overflow), 0);
      check("t5_h2_face", 32'(move_face), 2);
      check("t5_h2_ccw",  32'(move_ccw),  1);
      step();
      check("t5_h3_face",  32'(move_face),   3);
      check("t5_h3_count", 32'(queue_count), 3);
      step();
      check("t5_h4_face", 32'(move_face), 4);
      step();
      check("t5_h5_face", 32'(move_face), 5);
      check("t5_h5_ccw",  32'(move_ccw),  1);
      step();
      check("t5_drained", 32'(queue_count), 0);
      move_ready = 1'b0;
      repeat (6) step();

      // Reset with 3 queued moves, key held low through reset
      press_move(3'd0, 1'b0);
      press_move(3'd1, 1'b1);
      press_move(3'd2, 1'b0);
      check("t6_queued", 32'(queue_count), 3);
      SW_face  = 3'd3;
      SW_ccw   = 1'b1;
      KEY_move = 1'b0;
      reset    = 1'b1;
      step();
      check("t6_rst_valid", 32'(move_valid),  0);
      check("t6_rst_count", 32'(queue_count), 0);
      repeat (2) step();
      reset = 1'b0;
      found  = 1'b0;
      waited = 0;
      while (!found && waited < 12) begin
         step();
         waited++;
         if (move_valid) found = 1'b1;
      end
      check("t6_held_key_move", 32'(found), 1);
      check("t6_face",  32'(move_face),   3);
      check("t6_ccw",   32'(move_ccw),    1);
      check("t6_count", 32'(queue_count), 1);
      repeat (10) step();
      check("t6_single_move", 32'(queue_count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
